// File: rtl/fpu_fp16_to_int.sv
// fp16 to signed integer converter: one-bit-per-cycle shifter, RNE rounding,
// saturation and special-operand handling behind a valid/ready handshake.
module fpu_fp16_to_int #(
    parameter int unsigned INT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      fp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] int_out,
    output logic [2:0]       opStatusFlags
);

    localparam int unsigned MAG_W = 17;
    localparam int unsigned N_W   = 5;
    localparam int unsigned EXP_W = 5;

    // Magnitude is the integer weight when e = 25, so 25 is the no-shift point.
    localparam logic [EXP_W-1:0] E_UNITY = EXP_W'(25);
    localparam logic [MAG_W-1:0] MAX_POS_MAG = MAG_W'((32'd1 << (INT_W - 1)) - 32'd1);
    localparam logic [MAG_W-1:0] MIN_NEG_MAG = MAG_W'(32'd1 << (INT_W - 1));
    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic               g_q, g_d;
    logic               s_q, s_d;
    logic [N_W-1:0]     n_q, n_d;
    logic               left_q, left_d;
    logic               sign_q, sign_d;
    logic               nan_q, nan_d;
    logic               inf_q, inf_d;
    logic [INT_W-1:0]   int_out_q, int_out_d;
    logic [2:0]         flags_q, flags_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [EXP_W-1:0]   exp_c;
    logic [9:0]         frac_c;
    logic [EXP_W-1:0]   e_c;
    logic [10:0]        sig_c;
    logic               left_c;
    logic [N_W-1:0]     n_c;
    logic               special_c;
    logic               zero_c;

    logic               inc_c;
    logic [MAG_W-1:0]   mag_r_c;
    logic [INT_W-1:0]   res_c;
    logic               of_c;

    // Operand decode: effective exponent, significand and shift distance.
    always_comb begin
        exp_c     = fp_in[14:10];
        frac_c    = fp_in[9:0];
        e_c       = (exp_c == '0) ? EXP_W'(1) : exp_c;
        sig_c     = {exp_c != '0, frac_c};
        left_c    = e_c > E_UNITY;
        n_c       = left_c ? N_W'(e_c - E_UNITY) : N_W'(E_UNITY - e_c);
        special_c = exp_c == '1;
        zero_c    = (exp_c == '0) && (frac_c == '0);
    end

    // Rounding and saturation of the shifted magnitude.
    always_comb begin
        inc_c   = g_q & (s_q | mag_q[0]);
        mag_r_c = mag_q + MAG_W'(inc_c);
        of_c    = 1'b0;
        res_c   = '0;
        if (nan_q) begin
            of_c  = 1'b1;
            res_c = '0;
        end else if (inf_q) begin
            of_c  = 1'b1;
            res_c = sign_q ? INT_MIN : INT_MAX;
        end else if (!sign_q && (mag_r_c > MAX_POS_MAG)) begin
            of_c  = 1'b1;
            res_c = INT_MAX;
        end else if (sign_q && (mag_r_c > MIN_NEG_MAG)) begin
            of_c  = 1'b1;
            res_c = INT_MIN;
        end else if (sign_q) begin
            res_c = ~mag_r_c[INT_W-1:0] + INT_W'(1);
        end else begin
            res_c = mag_r_c[INT_W-1:0];
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        g_d       = g_q;
        s_d       = s_q;
        n_d       = n_q;
        left_d    = left_q;
        sign_d    = sign_q;
        nan_d     = nan_q;
        inf_d     = inf_q;
        int_out_d = int_out_q;
        flags_d   = flags_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = fp_in[15];
                    nan_d  = special_c && (frac_c != '0);
                    inf_d  = special_c && (frac_c == '0);
                    left_d = left_c;
                    g_d    = 1'b0;
                    s_d    = 1'b0;
                    if (special_c || zero_c) begin
                        mag_d   = '0;
                        n_d     = '0;
                        state_d = ROUND;
                    end else begin
                        mag_d   = MAG_W'(sig_c);
                        n_d     = n_c;
                        state_d = (n_c == '0) ? ROUND : SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d = mag_q >> 1;
                    g_d   = mag_q[0];
                    s_d   = s_q | g_q;
                end
                n_d = n_q - N_W'(1);
                if (n_q == N_W'(1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                int_out_d = res_c;
                flags_d   = {of_c, 1'b0, of_c ? 1'b0 : (g_q | s_q)};
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == DONE;
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            g_q         <= 1'b0;
            s_q         <= 1'b0;
            n_q         <= '0;
            left_q      <= 1'b0;
            sign_q      <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            int_out_q   <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            g_q         <= g_d;
            s_q         <= s_d;
            n_q         <= n_d;
            left_q      <= left_d;
            sign_q      <= sign_d;
            nan_q       <= nan_d;
            inf_q       <= inf_d;
            int_out_q   <= int_out_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign int_out       = int_out_q;
    assign opStatusFlags = flags_q;

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
// Self-checking bench for fpu_fp16_to_int (INT_W = 16).
module tb_fpu_fp16_to_int;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] fp_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] int_out;
    logic [2:0]  opStatusFlags;

    int n_total;
    int n_bad;

    fpu_fp16_to_int #(.INT_W(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .fp_in         (fp_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .int_out       (int_out),
        .opStatusFlags (opStatusFlags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // lat = number of rising edges after the accept edge until out_valid is
    // seen high; out_valid is then high in the cycle that edge k+lat+1 samples
    // (k+n+2 for shifted operands, k+2 for specials).
    typedef struct {
        logic [15:0] fp;
        logic [15:0] exp_int;
        logic [2:0]  exp_fl;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    // Reference: exact value sig*2^(e-25), round half to even, clamp to int16.
    function automatic void model(input logic [15:0] fp, output logic [15:0] r,
                                  output logic [2:0] fl, output int lat);
        int     ex, fr, e, sig, n;
        longint q, rem, half, v;
        bit     nx, of;
        ex = int'(fp[14:10]);
        fr = int'(fp[9:0]);
        lat = 1;
        if (ex == 31) begin
            r  = (fr != 0) ? 16'h0000 : (fp[15] ? 16'h8000 : 16'h7FFF);
            fl = 3'b100;
            return;
        end
        e   = (ex == 0) ? 1 : ex;
        sig = (ex != 0) ? 1024 + fr : fr;
        if (sig == 0) begin
            r  = 16'h0000;
            fl = 3'b000;
            return;
        end
        rem = 0;
        if (e >= 25) begin
            q   = longint'(sig) * (longint'(1) << (e - 25));
            lat = (e == 25) ? 1 : (e - 25) + 1;
        end else begin
            n    = 25 - e;
            q    = longint'(sig) / (longint'(1) << n);
            rem  = longint'(sig) % (longint'(1) << n);
            half = longint'(1) << (n - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            lat = n + 1;
        end
        nx = rem != 0;
        v  = fp[15] ? -q : q;
        of = 1'b0;
        if (v > 32767) begin
            r = 16'h7FFF; of = 1'b1;
        end else if (v < -32768) begin
            r = 16'h8000; of = 1'b1;
        end else begin
            r = 16'(v);
        end
        fl = {of, 1'b0, of ? 1'b0 : nx};
    endfunction

    // One conversion with optional backpressure of 'hold' cycles in DONE.
    task automatic run_op(input string name, input logic [15:0] fp, input int hold,
                          input logic [15:0] exp_r, input logic [2:0] exp_fl, input int exp_lat);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 60) begin
            @(posedge clock); #1; w++;
        end
        if (!in_ready) begin
            check({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
            return;
        end
        in_valid  = 1'b1;
        fp_in     = fp;
        out_ready = (hold == 0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        fp_in    = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_int"}, 32'(int_out), 32'(exp_r));
        check({name, "_flags"}, 32'(opStatusFlags), 32'(exp_fl));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom);
                fp_in    = 16'($urandom);
                @(posedge clock); #1;
                check({name, "_hold_int"}, 32'(int_out), 32'(exp_r));
                check({name, "_hold_flags"}, 32'(opStatusFlags), 32'(exp_fl));
                check({name, "_hold_vr"}, {30'd0, out_valid, in_ready}, 32'b10);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clock); #1;
            check({name, "_release_vr"}, {30'd0, out_valid, in_ready}, 32'b01);
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] r;
        logic [2:0]  fl;
        int          lat;
        logic [15:0] fp;
        int          quiet;

        n_total   = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        fp_in     = 16'h0000;
        out_ready = 1'b1;

        vecs.push_back('{16'h3E00, 16'h0002, 3'b001, 11});
        vecs.push_back('{16'h3A00, 16'h0001, 3'b001, 12});
        vecs.push_back('{16'h4100, 16'h0002, 3'b001, 10});
        vecs.push_back('{16'h3C00, 16'h0001, 3'b000, 11});
        vecs.push_back('{16'h7BFF, 16'h7FFF, 3'b100, 6});
        vecs.push_back('{16'hF800, 16'h8000, 3'b000, 6});
        vecs.push_back('{16'hF801, 16'h8000, 3'b100, 6});
        vecs.push_back('{16'h7E00, 16'h0000, 3'b100, 1});
        vecs.push_back('{16'hFC00, 16'h8000, 3'b100, 1});
        vecs.push_back('{16'h7C00, 16'h7FFF, 3'b100, 1});
        vecs.push_back('{16'h8000, 16'h0000, 3'b000, 1});
        vecs.push_back('{16'h6400, 16'h0400, 3'b000, 1});
        vecs.push_back('{16'h0001, 16'h0000, 3'b001, 25});
        vecs.push_back('{16'hBC00, 16'hFFFF, 3'b000, 11});
        vecs.push_back('{16'hC100, 16'hFFFE, 3'b001, 10});
        vecs.push_back('{16'h3800, 16'h0000, 3'b001, 12});
        vecs.push_back('{16'hB800, 16'h0000, 3'b001, 12});
        vecs.push_back('{16'h4000, 16'h0002, 3'b000, 10});

        // Reset values while reset_n is low.
        repeat (3) @(posedge clock);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_int_out", 32'(int_out), 32'd0);
        check("reset_flags", 32'(opStatusFlags), 32'd0);
        reset_n = 1'b1;

        // First operand is accepted on the first edge after reset release.
        run_op("first_accept", 16'h3C00, 0, 16'h0001, 3'b000, 11);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].fp, 0,
                   vecs[i].exp_int, vecs[i].exp_fl, vecs[i].exp_lat);
        end

        // Backpressure: five stalled cycles in DONE.
        run_op("bp_7BFF", 16'h7BFF, 5, 16'h7FFF, 3'b100, 6);
        run_op("bp_3A00", 16'h3A00, 5, 16'h0001, 3'b001, 12);

        // Random operands against the reference model.
        for (int t = 0; t < 300; t++) begin
            fp = 16'($urandom);
            model(fp, r, fl, lat);
            run_op($sformatf("rnd%0d_%04h", t, fp), fp, ($urandom_range(0, 3) == 0) ? 2 : 0,
                   r, fl, lat);
        end

        // Reset in the middle of a long right shift.
        run_op("pre_abort", 16'h3C00, 0, 16'h0001, 3'b000, 11);
        quiet = 0;
        while (!in_ready && quiet < 60) begin
            @(posedge clock); #1; quiet++;
        end
        in_valid = 1'b1;
        fp_in    = 16'h0001;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_int_out", 32'(int_out), 32'd0);
        check("abort_flags", 32'(opStatusFlags), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (out_valid || !in_ready) quiet++;
        end
        check("abort_no_result", 32'(quiet), 32'd0);
        run_op("after_abort", 16'h4000, 0, 16'h0002, 3'b000, 10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_fp16_to_int.md
FPU_FP16_TO_INT -- requirements
Module: fpu_fp16_to_int

Interface
REQ-001 Parameter INT_W, default 16, SHALL set the signed output integer width; legal range 8..16.
REQ-002 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL mark fp_in as valid.
REQ-005 in_ready  output  1  SHALL be high only in state IDLE.
REQ-006 fp_in  input  16  SHALL carry the fp16_t operand: sign[15], exp[14:10] (bias 15), frac[9:0].
REQ-007 out_valid  output  1  SHALL be high only in state DONE.
REQ-008 out_ready  input  1  SHALL be the consumer's acceptance of the result.
REQ-009 int_out  output  INT_W  SHALL carry the two's-complement result.
REQ-010 opStatusFlags  output  3  SHALL be {OF, UF, NX}; UF is always 0.

Function
REQ-011 Accept SHALL occur on an edge where in_valid & in_ready; fp_in is captured and the FSM leaves IDLE.
REQ-012 FSM states SHALL be IDLE, SHIFT, ROUND, DONE.
REQ-013 IDLE->SHIFT on accept if n>0; IDLE->ROUND on accept if n=0 or the operand is special (NaN/inf/zero).
REQ-014 Effective exponent e SHALL be exp, or 1 when exp=0; significand SHALL be {exp!=0, frac} (11 bits); value = sig * 2^(e-25).
REQ-015 Shift count n = |e-25|, 0..24; left shift when e>25, right shift when e<25.
REQ-016 SHIFT SHALL move the magnitude one bit per cycle and decrement n; SHIFT->ROUND when n reaches 0 after the shift.
REQ-017 On each right shift, the outgoing bit SHALL become guard G, and the previous G SHALL be ORed into sticky S.
REQ-018 Magnitude register SHALL be 17 bits wide, so that a left shift of 5 plus a rounding carry cannot wrap.
REQ-019 ROUND SHALL apply round-to-nearest-even: increment the magnitude if G & (S | mag[0]).
REQ-020 Saturation, applied after rounding:
- positive and mag > 2^(INT_W-1)-1 -> int_out = max positive, OF=1.
- negative and mag > 2^(INT_W-1) -> int_out = min negative, OF=1.
- mag = 2^(INT_W-1) with sign=1 is exact and SHALL NOT set OF.
REQ-021 Special operands:
- NaN -> int_out 0, OF=1.
- +inf -> max positive, OF=1.
- -inf -> min negative, OF=1.
- +/-0 -> int_out 0, flags 0.
REQ-022 NX SHALL be G|S when OF=0, and 0 when OF=1.
REQ-023 Negative in-range results SHALL be the two's complement of mag; a result of -0 SHALL output 0.
REQ-024 ROUND->DONE unconditionally; int_out and opStatusFlags are registered on entry to DONE.
REQ-025 Latency: for accept at edge k, out_valid SHALL rise after edge k+n+2 (k+2 for specials).
REQ-026 DONE SHALL hold int_out, opStatusFlags and out_valid stable while out_ready=0.
REQ-027 DONE->IDLE on the edge where out_ready=1; in_ready rises the following cycle, with no same-cycle re-accept.
REQ-028 in_valid while not IDLE SHALL be ignored, and fp_in changes after accept SHALL have no effect.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, out_valid=0, int_out=0, opStatusFlags=0, and clear the magnitude, G, S and n.
REQ-030 Reset asserted in SHIFT, ROUND or DONE SHALL abort the operation with no result emitted; in_ready=1 while reset_n=0 and afterwards.
REQ-031 The first accept SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-032 fp_in=16'h3E00 (1.5), out_ready=1 -> int_out=2, flags=3'b001; out_valid rises at k+12 (n=10).
REQ-033 Rounding cases:
- 16'h3A00 (0.75) -> 1, NX=1.
- 16'h4100 (2.5) -> 2, NX=1 (tie to even).
- 16'h3C00 (1.0) -> 1, flags 0.
REQ-034 Saturation cases:
- 16'h7BFF (65504) -> 16'h7FFF, flags 3'b100.
- 16'hF800 (-32768) -> 16'h8000, flags 0.
- 16'hF801 -> 16'h8000, OF=1.
REQ-035 Special cases:
- 16'h7E00 (NaN) -> 0, OF=1, out_valid at k+2.
- 16'hFC00 (-inf) -> 16'h8000, OF=1.
- 16'h8000 (-0) -> 0, flags 0.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; release -> IDLE next edge.
REQ-037 Reset mid-SHIFT (during 16'h0001 conversion, n=24) -> out_valid=0 and in_ready=1 immediately; next operand 16'h4000 -> 2.
